// File: rtl/cp0_pkg.sv
// Shared definitions for the exception sequencer: ExcCodes, Status bit
// positions, the default handler vector and the sequencer state encoding.
package cp0_pkg;

    localparam logic [4:0] EXC_INT     = 5'b00000;
    localparam logic [4:0] EXC_SYSCALL = 5'b01000;
    localparam logic [4:0] EXC_BREAK   = 5'b01001;
    localparam logic [4:0] EXC_TEQ     = 5'b01101;

    localparam int ST_IE      = 0;
    localparam int ST_SYS_EN  = 1;
    localparam int ST_BRK_EN  = 2;
    localparam int ST_TEQ_EN  = 3;
    localparam int ST_IM_BASE = 8;

    localparam logic [31:0] VEC_ADDR_DEF = 32'h0040_0004;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_VECTOR  = 3'd2,
        S_HANDLER = 3'd3,
        S_RET     = 3'd4,
        S_RET_JMP = 3'd5
    } exc_state_e;

    // Synchronous causes resume after the faulting instruction; interrupts
    // resume at the interrupted instruction, which never executed.
    function automatic logic resumes_after(input logic [4:0] cause);
        return (cause != EXC_INT);
    endfunction

endpackage

// File: rtl/exc_prio_arb.sv
// Combinational mask and fixed-priority pick between synchronous requests
// and pending interrupts. Grant layout: {teq, syscall, break, irq[IRQ_W-1:0]}.
module exc_prio_arb
    import cp0_pkg::*;
#(
    parameter int IRQ_W = 4
) (
    input  logic             req_syscall,
    input  logic             req_break,
    input  logic             req_teq,
    input  logic [IRQ_W-1:0] irq_pend,
    input  logic [31:0]      status_in,
    output logic [IRQ_W+2:0] grant,
    output logic [4:0]       cause
);

    localparam int G_BRK = IRQ_W;
    localparam int G_SYS = IRQ_W + 1;
    localparam int G_TEQ = IRQ_W + 2;

    logic [IRQ_W-1:0] irq_en_s;
    logic             irq_found_s;
    logic             unused_status_s;

    assign irq_en_s        = irq_pend & status_in[ST_IM_BASE +: IRQ_W];
    assign unused_status_s = ^status_in;

    // Pick one winner: BREAK > SYSCALL > TEQ > lowest-index enabled irq.
    always_comb begin
        grant       = '0;
        cause       = EXC_INT;
        irq_found_s = 1'b0;
        if (!status_in[ST_IE]) begin
            grant = '0;
        end else if (req_break && status_in[ST_BRK_EN]) begin
            grant[G_BRK] = 1'b1;
            cause        = EXC_BREAK;
        end else if (req_syscall && status_in[ST_SYS_EN]) begin
            grant[G_SYS] = 1'b1;
            cause        = EXC_SYSCALL;
        end else if (req_teq && status_in[ST_TEQ_EN]) begin
            grant[G_TEQ] = 1'b1;
            cause        = EXC_TEQ;
        end else begin
            for (int i = 0; i < IRQ_W; i++) begin
                grant[i]    = irq_en_s[i] & ~irq_found_s;
                irq_found_s = irq_found_s | irq_en_s[i];
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: tracks pending interrupts, runs the entry/return
// handshake with CP0 and stalls/redirects the PC around it.
module exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          IRQ_W    = 4,
    parameter logic [31:0] VEC_ADDR = VEC_ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_in,
    input  logic             req_syscall,
    input  logic             req_break,
    input  logic             req_teq,
    input  logic             req_eret,
    input  logic [IRQ_W-1:0] irq,
    input  logic [31:0]      status_in,
    input  logic [31:0]      epc_in,
    output logic             cp0_exc,
    output logic [4:0]       cp0_cause,
    output logic [31:0]      cp0_epc,
    output logic             cp0_eret,
    output logic             stall,
    output logic             redirect,
    output logic [31:0]      pc_target,
    output logic             in_handler,
    output logic             double_fault
);

    exc_state_e       state_q, state_d;
    logic [4:0]       cause_q, cause_d;
    logic [31:0]      epc_q, epc_d;
    logic [IRQ_W-1:0] irq_prev_q, irq_prev_d;
    logic [IRQ_W-1:0] irq_pend_q, irq_pend_d;
    logic             dfault_q, dfault_d;

    logic [IRQ_W+2:0] arb_grant_s;
    logic [4:0]       arb_cause_s;
    logic             arb_valid_s;
    logic [IRQ_W-1:0] irq_ack_s;
    logic             sync_any_s;

    exc_prio_arb #(.IRQ_W(IRQ_W)) u_arb (
        .req_syscall (req_syscall),
        .req_break   (req_break),
        .req_teq     (req_teq),
        .irq_pend    (irq_pend_q),
        .status_in   (status_in),
        .grant       (arb_grant_s),
        .cause       (arb_cause_s)
    );

    assign arb_valid_s = |arb_grant_s;
    assign sync_any_s  = req_syscall | req_break | req_teq;

    // Next-state, latched cause/PC, pending-irq update and output decode.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        dfault_d     = dfault_q;
        irq_ack_s    = '0;
        cp0_exc      = 1'b0;
        cp0_cause    = 5'b00000;
        cp0_epc      = 32'h0000_0000;
        cp0_eret     = 1'b0;
        stall        = 1'b0;
        redirect     = 1'b0;
        pc_target    = 32'h0000_0000;
        in_handler   = 1'b0;
        double_fault = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_valid_s) begin
                    state_d   = S_ENTRY;
                    cause_d   = arb_cause_s;
                    epc_d     = pc_in;
                    irq_ack_s = arb_grant_s[IRQ_W-1:0];
                    stall     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ENTRY: begin
                cp0_exc   = 1'b1;
                cp0_cause = cause_q;
                cp0_epc   = epc_q;
                stall     = 1'b1;
                state_d   = S_VECTOR;
            end
            S_VECTOR: begin
                redirect  = 1'b1;
                pc_target = VEC_ADDR;
                state_d   = S_HANDLER;
            end
            S_HANDLER: begin
                in_handler = 1'b1;
                if (sync_any_s) begin
                    dfault_d = 1'b1;
                end else begin
                    dfault_d = dfault_q;
                end
                if (req_eret) begin
                    stall   = 1'b1;
                    state_d = S_RET;
                end else begin
                    state_d = S_HANDLER;
                end
            end
            S_RET: begin
                cp0_eret = 1'b1;
                stall    = 1'b1;
                state_d  = S_RET_JMP;
            end
            S_RET_JMP: begin
                redirect  = 1'b1;
                pc_target = resumes_after(cause_q) ? (epc_in + 32'd4) : epc_in;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        irq_pend_d = (irq_pend_q | (irq & ~irq_prev_q)) & ~irq_ack_s;
        irq_prev_d = irq;

        // Reset silences every output in the same cycle, including strobes.
        if (rst) begin
            cp0_exc      = 1'b0;
            cp0_cause    = 5'b00000;
            cp0_epc      = 32'h0000_0000;
            cp0_eret     = 1'b0;
            stall        = 1'b0;
            redirect     = 1'b0;
            pc_target    = 32'h0000_0000;
            in_handler   = 1'b0;
            double_fault = 1'b0;
        end else begin
            double_fault = dfault_q;
        end
    end

    // State, latched exception context, irq edge/pending and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cause_q    <= 5'b00000;
            epc_q      <= 32'h0000_0000;
            irq_prev_q <= '0;
            irq_pend_q <= '0;
            dfault_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            irq_prev_q <= irq_prev_d;
            irq_pend_q <= irq_pend_d;
            dfault_q   <= dfault_d;
        end
    end

endmodule
